// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives imem, fills the IF/ID register.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic        o_if_valid,
  output logic        o_misaligned,
  output logic        o_halted,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_bubble_cnt
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            if_valid_q, if_valid_d;
  logic            misaligned_q, misaligned_d;
  logic            halted_q;
  logic            load_valid, load_bubble;
  logic [XLEN-1:0] pc_inc, redirect_target;

  assign pc_inc          = pc_q + XLEN'(4);
  assign redirect_target = {i_redirect_pc[XLEN-1:2], 2'b00};

  // State, PC and IF/ID registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      if_pc_q      <= '0;
      if_instr_q   <= NOP_INSTR;
      if_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      if_valid_q   <= if_valid_d;
      misaligned_q <= misaligned_d;
      halted_q     <= (state_d == HALT);
    end
  end

  // Next-state / next-PC resolution; redirect has top priority, then halt, flush, stall
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    load_valid   = 1'b0;
    load_bubble  = 1'b0;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if_valid_d   = if_valid_q;

    case (state_q)
      BOOT: begin
        load_bubble = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (i_redirect_valid) begin
          pc_d         = redirect_target;
          misaligned_d = |i_redirect_pc[1:0];
          load_bubble  = 1'b1;
        end else if (i_halt) begin
          state_d     = HALT;
          load_bubble = 1'b1;
        end else if (i_flush) begin
          load_bubble = 1'b1;
          if (!i_stall) pc_d = pc_inc;
        end else if (!i_stall) begin
          load_valid = 1'b1;
          pc_d       = pc_inc;
        end
      end
      HALT: begin
        load_bubble = 1'b1;
        if (i_redirect_valid) begin
          pc_d         = redirect_target;
          misaligned_d = |i_redirect_pc[1:0];
          state_d      = RUN;
        end
      end
      default: begin
        state_d     = BOOT;
        load_bubble = 1'b1;
      end
    endcase

    if (load_bubble) begin
      if_pc_d    = pc_q;
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end else if (load_valid) begin
      if_pc_d    = pc_q;
      if_instr_d = i_imem_rdata;
      if_valid_d = 1'b1;
    end
  end

  assign o_imem_addr  = pc_q;
  assign o_if_pc      = if_pc_q;
  assign o_if_instr   = if_instr_q;
  assign o_if_valid   = if_valid_q;
  assign o_misaligned = misaligned_q;
  assign o_halted     = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, bubble_cnt_q;

  // Saturating fetch / bubble counters; stall-hold edges count neither
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (load_valid && (fetch_cnt_q != '1))
        fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
      if (load_bubble && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + XLEN'(1);
    end
  end

  assign o_fetch_cnt  = fetch_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
`else
  assign o_fetch_cnt  = '0;
  assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a per-edge reference model queues expected outputs,
// a monitor compares them against the DUT one step after each rising edge.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int MODE_BOOT = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_HALT = 2;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_halt = 1'b0;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_if_pc, o_if_instr;
  logic        o_if_valid, o_misaligned, o_halted;
  logic [31:0] o_fetch_cnt, o_bubble_cnt;

  typedef struct packed {
    logic [31:0] imem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        misaligned;
    logic        halted;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int          m_mode = MODE_BOOT;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_if_pc = '0;
  logic [31:0] m_if_instr = NOP_INSTR;
  logic        m_if_valid = 1'b0;
  logic        m_mis = 1'b0;
  longint      m_fcnt = 0;
  longint      m_bcnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign i_imem_rdata = imem_word(o_imem_addr);

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc), .i_halt(i_halt),
    .o_imem_addr(o_imem_addr), .i_imem_rdata(i_imem_rdata),
    .o_if_pc(o_if_pc), .o_if_instr(o_if_instr), .o_if_valid(o_if_valid),
    .o_misaligned(o_misaligned), .o_halted(o_halted),
    .o_fetch_cnt(o_fetch_cnt), .o_bubble_cnt(o_bubble_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one edge's inputs and push the model's view of the outputs after that edge
  task automatic step(input logic rst, input logic st, input logic fl, input logic rv,
                      input logic [31:0] rpc, input logic hl);
    exp_t e;
    logic [31:0] old_pc;
    bit bubble, valid_load;
    @(negedge clk);
    i_reset = rst; i_stall = st; i_flush = fl;
    i_redirect_valid = rv; i_redirect_pc = rpc; i_halt = hl;
    old_pc = m_pc; bubble = 0; valid_load = 0; m_mis = 1'b0;
    if (!rst) begin
      m_mode = MODE_BOOT; m_pc = RESET_PC; m_if_pc = '0; m_if_instr = NOP_INSTR;
      m_if_valid = 1'b0; m_fcnt = 0; m_bcnt = 0;
    end else if (m_mode == MODE_BOOT) begin
      bubble = 1; m_mode = MODE_RUN;
    end else if (m_mode == MODE_HALT) begin
      bubble = 1;
      if (rv) begin
        m_pc = rpc & ~32'd3; m_mis = (rpc % 4) != 0; m_mode = MODE_RUN;
      end
    end else begin
      if (rv) begin
        bubble = 1; m_pc = rpc & ~32'd3; m_mis = (rpc % 4) != 0;
      end else if (hl) begin
        bubble = 1; m_mode = MODE_HALT;
      end else if (fl) begin
        bubble = 1;
        if (!st) m_pc = m_pc + 32'd4;
      end else if (!st) begin
        valid_load = 1; m_pc = m_pc + 32'd4;
      end
    end
    if (bubble) begin
      m_if_valid = 1'b0; m_if_instr = NOP_INSTR; m_if_pc = old_pc;
      if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
    end else if (valid_load) begin
      m_if_valid = 1'b1; m_if_instr = imem_word(old_pc); m_if_pc = old_pc;
      if (m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
    end
    e.imem_addr  = m_pc;
    e.if_pc      = m_if_pc;
    e.if_instr   = m_if_instr;
    e.if_valid   = m_if_valid;
    e.misaligned = m_mis;
    e.halted     = (m_mode == MODE_HALT);
`ifdef FETCH_PERF_CNT_EN
    e.fetch_cnt  = m_fcnt[31:0];
    e.bubble_cnt = m_bcnt[31:0];
`else
    e.fetch_cnt  = '0;
    e.bubble_cnt = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: compare the oldest expectation just after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("imem_addr",  o_imem_addr,         e.imem_addr);
      chk("if_pc",      o_if_pc,             e.if_pc);
      chk("if_instr",   o_if_instr,          e.if_instr);
      chk("if_valid",   32'(o_if_valid),     32'(e.if_valid));
      chk("misaligned", 32'(o_misaligned),   32'(e.misaligned));
      chk("halted",     32'(o_halted),       32'(e.halted));
      chk("fetch_cnt",  o_fetch_cnt,         e.fetch_cnt);
      chk("bubble_cnt", o_bubble_cnt,        e.bubble_cnt);
    end
  end

  initial begin
    int guard;
    // Reset then free-run up to o_if_pc = 8
    step(1'b0, 0, 0, 0, 32'h0, 0);
    step(1'b0, 0, 0, 0, 32'h0, 0);
    run(4);
    // Stall 3 cycles while o_if_pc = 8
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    run(3);
    // Redirect together with stall and flush
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
    run(3);
    // Misaligned redirect
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h202, 1'b0);
    run(3);
    // PC wrap
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run(3);
    // Halt at 0x40, hold, redirect out
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b1, k[0], k[1], 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
    run(3);
    // Halt again, then reset mid-halt
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    run(3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    run(4);
    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic rst, st, fl, rv, hl;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 99) != 0);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      hl  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      step(rst, st, fl, rv, rpc, hl);
    end
    run(2);
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
